// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one async_fifo write port; zero-latency write, fifo_full stalls the grant.
// Define FIFO_WR_ARB_STATS_EN to add per-requester saturating word counters (req_word_count).
module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_write_en,
  output logic [DATA_WIDTH-1:0]         fifo_write_data,
  output logic [IDW-1:0]                grant_id,
`ifdef FIFO_WR_ARB_STATS_EN
  output logic                          busy,
  output logic [NUM_REQ*16-1:0]         req_word_count
`else
  output logic                          busy
`endif
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state;
  logic [IDW-1:0]          last_grant;
  logic [7:0]              burst_cnt;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   req_word [NUM_REQ];
  logic [IDW-1:0]          winner;
  logic [IDW-1:0]          scan_id;
  logic                    any_req;
  int                      scan_idx;
  logic                    xfer;
  logic                    burst_done;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_word[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Rotating priority: first valid requester after the previous winner.
  always_comb begin
    winner   = '0;
    any_req  = 1'b0;
    scan_idx = 0;
    scan_id  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (int'(last_grant) + k) % NUM_REQ;
      scan_id  = IDW'(scan_idx);
      if (!any_req && req_valid[scan_id]) begin
        any_req = 1'b1;
        winner  = scan_id;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == GRANT && !fifo_full) req_ready[grant_id] = 1'b1;
  end

  assign xfer            = (state == GRANT) && req_valid[grant_id] && !fifo_full;
  assign fifo_write_en   = xfer;
  assign fifo_write_data = xfer ? req_word[grant_id] : wdata_q;
  assign burst_done      = ({1'b0, burst_cnt} + 9'd1) == 9'(MAX_BURST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      grant_id   <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
      burst_cnt  <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req && !fifo_full) begin
            grant_id  <= winner;
            busy      <= 1'b1;
            burst_cnt <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) begin
            wdata_q   <= req_word[grant_id];
            burst_cnt <= burst_cnt + 8'd1;
            if (req_last[grant_id] || burst_done) begin
              state      <= IDLE;
              busy       <= 1'b0;
              last_grant <= grant_id;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_word_count <= '0;
    end else if (xfer) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == int'(grant_id) && req_word_count[i*16 +: 16] != 16'hFFFF)
          req_word_count[i*16 +: 16] <= req_word_count[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule
